vc_pop_scheduler: RTL and testbench

- Sequences reads from the two virtual-channel FIFOs (VC0 high priority, VC1 low priority) and steers each popped word to destination FIFO D0 or D1.
- Sits between the VC FIFOs and the D0/D1 FIFOs in the interconnect.
- VC0 wins by default. A weighted anti-starvation counter forces a VC1 grant after WEIGHT consecutive VC0 grants that occurred while VC1 was waiting.
- Tracks the one-cycle VC FIFO read latency internally and pushes the destination FIFO in the cycle the data arrives.

---
 rtl/vc_pop_scheduler.sv | 69 ++++++
 tb/tb_vc_pop_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vc_pop_scheduler.sv
// Pops the two virtual-channel FIFOs (VC0 preferred, VC1 protected by a weighted
// anti-starvation counter) and steers each word to D0 or D1 one cycle after the pop.
module vc_pop_scheduler #(
   parameter int DATA_WIDTH = 6,
   parameter int DEST_BIT   = 4,
   parameter int WEIGHT     = 4
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  VC0_empty,
   input  logic                  VC1_empty,
   input  logic [DATA_WIDTH-1:0] VC0_data,
   input  logic [DATA_WIDTH-1:0] VC1_data,
   input  logic                  D0_pause,
   input  logic                  D1_pause,
   output logic                  VC0_rd,
   output logic                  VC1_rd,
   output logic                  D0_push,
   output logic                  D1_push,
   output logic [DATA_WIDTH-1:0] D_data,
   output logic                  vc0_delay,
   output logic                  stall
);

   localparam logic [3:0] WEIGHT_C = 4'(WEIGHT);

   logic       ok;
   logic       force1;
   logic [3:0] wcnt;
   logic       vld_p1;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v >= WEIGHT_C) ? WEIGHT_C : v + 4'd1;
   endfunction

   // Stage p0: grant decision. Both destinations need room since the target is unknown until the word arrives.
   always_comb begin
      ok     = !D0_pause && !D1_pause;
      force1 = (WEIGHT_C != 4'd0) && (wcnt == WEIGHT_C) && !VC1_empty;
      VC1_rd = reset_L && ok && !VC1_empty && (VC0_empty || force1);
      VC0_rd = reset_L && ok && !VC0_empty && !VC1_rd;
      stall  = !ok && (!VC0_empty || !VC1_empty);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wcnt      <= 4'd0;
         vld_p1    <= 1'b0;
         vc0_delay <= 1'b0;
      end else begin
         if (VC1_rd)
            wcnt <= 4'd0;
         else if (VC0_rd && !VC1_empty)
            wcnt <= sat_inc(wcnt);
         else if (VC1_empty)
            wcnt <= 4'd0;
         vld_p1    <= VC0_rd || VC1_rd;
         vc0_delay <= VC1_rd;
      end
   end

   // Stage p1: FIFO read data arrives; select source and route on the destination bit.
   always_comb begin
      D_data  = vc0_delay ? VC1_data : VC0_data;
      D0_push = vld_p1 && !D_data[DEST_BIT];
      D1_push = vld_p1 && D_data[DEST_BIT];
   end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Scoreboard bench for vc_pop_scheduler: directed FIFO contents, expected pushes queued
// by the stimulus and consumed by an independent monitor.
module tb_vc_pop_scheduler;

   localparam int DW = 6;

   logic          clk = 1'b0;
   logic          reset_L;
   logic          VC0_empty, VC1_empty;
   logic [DW-1:0] VC0_data, VC1_data;
   logic          D0_pause, D1_pause;
   logic          VC0_rd, VC1_rd, D0_push, D1_push, vc0_delay, stall;
   logic [DW-1:0] D_data;

   logic          s_vc0_empty, s_vc1_empty;
   logic [DW-1:0] s_vc0_data, s_vc1_data;
   logic          s_vc0_rd, s_vc1_rd, s_d0_push, s_d1_push, s_vc0_delay, s_stall;
   logic [DW-1:0] s_d_data;

   int checks = 0;
   int fails  = 0;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          d1;
      logic          vc1;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   vc_pop_scheduler #(.DATA_WIDTH(DW), .DEST_BIT(4), .WEIGHT(4)) u_dut (
      .clk(clk), .reset_L(reset_L),
      .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
      .VC0_data(VC0_data), .VC1_data(VC1_data),
      .D0_pause(D0_pause), .D1_pause(D1_pause),
      .VC0_rd(VC0_rd), .VC1_rd(VC1_rd),
      .D0_push(D0_push), .D1_push(D1_push),
      .D_data(D_data), .vc0_delay(vc0_delay), .stall(stall)
   );

   vc_pop_scheduler #(.DATA_WIDTH(DW), .DEST_BIT(4), .WEIGHT(0)) u_strict (
      .clk(clk), .reset_L(reset_L),
      .VC0_empty(s_vc0_empty), .VC1_empty(s_vc1_empty),
      .VC0_data(s_vc0_data), .VC1_data(s_vc1_data),
      .D0_pause(1'b0), .D1_pause(1'b0),
      .VC0_rd(s_vc0_rd), .VC1_rd(s_vc1_rd),
      .D0_push(s_d0_push), .D1_push(s_d1_push),
      .D_data(s_d_data), .vc0_delay(s_vc0_delay), .stall(s_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic exp_push(input logic [DW-1:0] d, input logic d1, input logic vc1);
      exp_t e;
      e.data = d;
      e.d1   = d1;
      e.vc1  = vc1;
      sb.push_back(e);
   endtask

   // One clock: sample the pops, then model the FIFOs' one-cycle read latency.
   task automatic step();
      logic r0, r1;
      @(negedge clk);
      r0 = VC0_rd;
      r1 = VC1_rd;
      @(posedge clk);
      #1;
      if (r0 && q0.size() > 0) VC0_data = q0.pop_front();
      if (r1 && q1.size() > 0) VC1_data = q1.pop_front();
      VC0_empty = (q0.size() == 0);
      VC1_empty = (q1.size() == 0);
      #1;
   endtask

   always @(negedge clk) begin
      if (reset_L && (D0_push || D1_push)) begin
         chk("push_onehot", int'(D0_push && D1_push), 0);
         chk("sb_has_entry", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("push_data", int'(D_data), int'(mon_e.data));
            chk("push_dest", int'(D1_push), int'(mon_e.d1));
            chk("push_vc0_delay", int'(vc0_delay), int'(mon_e.vc1));
         end
      end
   end

   initial begin
      int n0, n1;
      reset_L     = 1'b0;
      VC0_data    = '0;
      VC1_data    = '0;
      D0_pause    = 1'b0;
      D1_pause    = 1'b0;
      s_vc0_empty = 1'b1;
      s_vc1_empty = 1'b1;
      s_vc0_data  = '0;
      s_vc1_data  = '0;
      q0 = '{6'h05, 6'h15};
      VC0_empty = 1'b0;
      VC1_empty = 1'b1;

      // Reset held with VC0 non-empty
      repeat (2) @(posedge clk);
      #2;
      chk("rst_vc0_rd", int'(VC0_rd), 0);
      chk("rst_vc1_rd", int'(VC1_rd), 0);
      chk("rst_d0_push", int'(D0_push), 0);
      chk("rst_d1_push", int'(D1_push), 0);
      chk("rst_vc0_delay", int'(vc0_delay), 0);

      // Release and routing
      @(posedge clk);
      #1 reset_L = 1'b1;
      #1;
      chk("rel_vc0_rd", int'(VC0_rd), 1);
      chk("rel_stall", int'(stall), 0);
      exp_push(6'h05, 1'b0, 1'b0);
      exp_push(6'h15, 1'b1, 1'b0);
      step();
      chk("route_vc0_rd2", int'(VC0_rd), 1);
      step();
      chk("route_vc0_idle", int'(VC0_rd), 0);
      step();

      // Backpressure
      q0 = '{6'h21, 6'h33, 6'h04};
      VC0_empty = 1'b0;
      #1;
      chk("bp_vc0_rd", int'(VC0_rd), 1);
      exp_push(6'h21, 1'b0, 1'b0);
      exp_push(6'h33, 1'b1, 1'b0);
      exp_push(6'h04, 1'b0, 1'b0);
      step();
      D1_pause = 1'b1;
      #1;
      chk("bp_paused_rd", int'(VC0_rd), 0);
      chk("bp_stall", int'(stall), 1);
      chk("bp_inflight_push", int'(D0_push), 1);
      step();
      D1_pause = 1'b0;
      #1;
      chk("bp_resume_rd", int'(VC0_rd), 1);
      repeat (4) step();
      D0_pause = 1'b1;
      #1;
      chk("bp_empty_no_stall", int'(stall), 0);
      D0_pause = 1'b0;

      // Anti-starvation with WEIGHT=4: grants 0,0,0,0,1,0,0,0,0,1
      q0 = '{6'h01, 6'h12, 6'h03, 6'h14, 6'h05, 6'h16, 6'h07, 6'h18};
      q1 = '{6'h2A, 6'h3B};
      VC0_empty = 1'b0;
      VC1_empty = 1'b0;
      exp_push(6'h01, 1'b0, 1'b0);
      exp_push(6'h12, 1'b1, 1'b0);
      exp_push(6'h03, 1'b0, 1'b0);
      exp_push(6'h14, 1'b1, 1'b0);
      exp_push(6'h2A, 1'b0, 1'b1);
      exp_push(6'h05, 1'b0, 1'b0);
      exp_push(6'h16, 1'b1, 1'b0);
      exp_push(6'h07, 1'b0, 1'b0);
      exp_push(6'h18, 1'b1, 1'b0);
      exp_push(6'h3B, 1'b1, 1'b1);
      #1;
      chk("as_first_vc0", int'(VC0_rd), 1);
      repeat (12) step();

      // Mid-operation reset right after a VC1 pop
      q1 = '{6'h2A};
      VC1_empty = 1'b0;
      #1;
      chk("mr_vc1_rd", int'(VC1_rd), 1);
      step();
      reset_L = 1'b0;
      q0.delete();
      q1.delete();
      VC0_empty = 1'b1;
      VC1_empty = 1'b1;
      #1;
      chk("mr_d0_push", int'(D0_push), 0);
      chk("mr_d1_push", int'(D1_push), 0);
      chk("mr_vc0_delay", int'(vc0_delay), 0);
      chk("mr_wcnt", int'(u_dut.wcnt), 0);
      q0 = '{6'h07};
      q1 = '{6'h39};
      VC0_empty = 1'b0;
      VC1_empty = 1'b0;
      #1;
      chk("mr_hold_vc0_rd", int'(VC0_rd), 0);
      chk("mr_hold_vc1_rd", int'(VC1_rd), 0);
      exp_push(6'h07, 1'b0, 1'b0);
      exp_push(6'h39, 1'b1, 1'b1);
      @(posedge clk);
      #1 reset_L = 1'b1;
      #1;
      chk("mr_first_vc0", int'(VC0_rd), 1);
      chk("mr_first_not_vc1", int'(VC1_rd), 0);
      repeat (3) step();

      // Strict priority instance, WEIGHT=0
      s_vc0_empty = 1'b0;
      s_vc1_empty = 1'b0;
      n0 = 0;
      n1 = 0;
      repeat (20) begin
         @(negedge clk);
         n0 += int'(s_vc0_rd);
         n1 += int'(s_vc1_rd);
      end
      chk("strict_vc0_pops", n0, 20);
      chk("strict_vc1_pops", n1, 0);
      @(posedge clk);
      #1 s_vc0_empty = 1'b1;
      #1;
      chk("strict_vc1_after_empty", int'(s_vc1_rd), 1);

      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
